// File: rtl/key_debounce_if.sv
// rtl/key_debounce_if.sv - key pins and conditioned key outputs bundle
interface key_debounce_if #(
    parameter int KEY_NUM = 2
);
    logic [KEY_NUM-1:0] key_in;
    logic [KEY_NUM-1:0] key_signal;
    logic [KEY_NUM-1:0] key_level;
    logic [KEY_NUM-1:0] key_long;

    modport master (output key_in, input key_signal, key_level, key_long);
    modport slave  (input key_in, output key_signal, key_level, key_long);
endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - per-channel key synchroniser, debounce FSM and press/long-press pulses
// Optional long-press logic built only when KEY_LONG_PRESS_EN is defined.
module key_debounce #(
    parameter int KEY_NUM     = 2,
    parameter int CLK_FREQ    = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000
) (
    input  logic             sclk,
    input  logic             nrst,
    key_debounce_if.slave    keys
);
    localparam int DEB_CYCLES  = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int LONG_CYCLES = CLK_FREQ / 1000 * LONG_MS;
    localparam int DW          = $clog2(DEB_CYCLES + 1);

    localparam logic [1:0] S_IDLE        = 2'd0;
    localparam logic [1:0] S_PRESS_CHK   = 2'd1;
    localparam logic [1:0] S_HELD        = 2'd2;
    localparam logic [1:0] S_RELEASE_CHK = 2'd3;

    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    if (DEB_CYCLES < 2 || LONG_CYCLES <= DEB_CYCLES) begin : g_bad_params
        $error("key_debounce: DEB_CYCLES must be >= 2 and LONG_CYCLES > DEB_CYCLES");
    end

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
        logic          sync1;
        logic          ks;
        logic [1:0]    state;
        logic [DW-1:0] deb_cnt;
        logic          sig_q;
        logic          lvl_q;

        // The counter value that would be reached this edge is DEB_CYCLES when it currently holds DEB_LAST.
        always_ff @(posedge sclk or negedge nrst) begin
            if (!nrst) begin
                sync1   <= 1'b1;
                ks      <= 1'b1;
                state   <= S_IDLE;
                deb_cnt <= '0;
                sig_q   <= 1'b0;
                lvl_q   <= 1'b0;
            end else begin
                sync1 <= keys.key_in[i];
                ks    <= sync1;
                sig_q <= 1'b0;
                case (state)
                    S_IDLE: begin
                        if (!ks) begin
                            state   <= S_PRESS_CHK;
                            deb_cnt <= DW'(1);
                        end
                    end
                    S_PRESS_CHK: begin
                        if (ks) begin
                            state   <= S_IDLE;
                            deb_cnt <= '0;
                        end else if (deb_cnt == DEB_LAST) begin
                            state   <= S_HELD;
                            deb_cnt <= deb_cnt + 1'b1;
                            sig_q   <= 1'b1;
                            lvl_q   <= 1'b1;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end
                    S_HELD: begin
                        if (ks) begin
                            state   <= S_RELEASE_CHK;
                            deb_cnt <= DW'(1);
                        end
                    end
                    S_RELEASE_CHK: begin
                        if (!ks) begin
                            state   <= S_HELD;
                            deb_cnt <= '0;
                        end else if (deb_cnt == DEB_LAST) begin
                            state   <= S_IDLE;
                            deb_cnt <= '0;
                            lvl_q   <= 1'b0;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state   <= S_IDLE;
                        deb_cnt <= '0;
                        lvl_q   <= 1'b0;
                    end
                endcase
            end
        end

        assign keys.key_signal[i] = sig_q;
        assign keys.key_level[i]  = lvl_q;

`ifdef KEY_LONG_PRESS_EN
        localparam int HW = $clog2(LONG_CYCLES + 1);
        localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
        localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

        logic [HW-1:0] hold_cnt;
        logic          long_q;

        // Hold count only advances in HELD and saturates, so one long pulse per press.
        always_ff @(posedge sclk or negedge nrst) begin
            if (!nrst) begin
                hold_cnt <= '0;
                long_q   <= 1'b0;
            end else begin
                long_q <= 1'b0;
                if (state == S_IDLE) begin
                    hold_cnt <= '0;
                end else if (state == S_HELD && hold_cnt != HOLD_MAX) begin
                    hold_cnt <= hold_cnt + 1'b1;
                    long_q   <= (hold_cnt == HOLD_LAST);
                end
            end
        end

        assign keys.key_long[i] = long_q;
`else
        assign keys.key_long[i] = 1'b0;
`endif
    end
endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - directed self-checking bench for key_debounce (DEB_CYCLES=8, LONG_CYCLES=40)
module tb_key_debounce;
    logic sclk;
    logic nrst;
    int   vectors;
    int   miscompares;
    int   long_cnt;
    int   long_at;

`ifdef KEY_LONG_PRESS_EN
    localparam logic LE = 1'b1;
`else
    localparam logic LE = 1'b0;
`endif

    key_debounce_if #(.KEY_NUM(2)) kif ();

    key_debounce #(
        .KEY_NUM    (2),
        .CLK_FREQ   (1000),
        .DEBOUNCE_MS(8),
        .LONG_MS    (40)
    ) dut (
        .sclk(sclk),
        .nrst(nrst),
        .keys(kif)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic tick(input int n);
        repeat (n) @(posedge sclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        nrst        = 1'b0;
        kif.key_in  = 2'b11;
        tick(3);
        check("reset_signal", 32'(kif.key_signal), 32'd0);
        check("reset_level",  32'(kif.key_level),  32'd0);
        check("reset_long",   32'(kif.key_long),   32'd0);
        nrst = 1'b1;
        tick(5);
        check("idle_level", 32'(kif.key_level), 32'd0);

        // Clean press on key 0: pulse 10 edges after fall, long 40 after pulse, level drop 10 after rise
        kif.key_in[0] = 1'b0;
        tick(9);
        check("clean_sig_early", 32'(kif.key_signal), 32'd0);
        tick(1);
        check("clean_sig", 32'(kif.key_signal), 32'b01);
        check("clean_level", 32'(kif.key_level), 32'b01);
        tick(1);
        check("clean_sig_once", 32'(kif.key_signal), 32'd0);
        tick(38);
        check("clean_long_early", 32'(kif.key_long), 32'd0);
        tick(1);
        check("clean_long", 32'(kif.key_long), 32'(LE));
        tick(1);
        check("clean_long_once", 32'(kif.key_long), 32'd0);
        tick(9);
        kif.key_in[0] = 1'b1;
        tick(9);
        check("rel_level_held", 32'(kif.key_level), 32'b01);
        tick(1);
        check("rel_level_drop", 32'(kif.key_level), 32'd0);
        tick(5);

        // Bouncy press on key 1: 3-cycle segments never debounce
        for (int s = 0; s < 10; s++) begin
            kif.key_in[1] = s[0];
            for (int c = 0; c < 3; c++) begin
                tick(1);
                check("bounce_no_sig", 32'(kif.key_signal), 32'd0);
            end
        end
        kif.key_in[1] = 1'b0;
        for (int c = 0; c < 9; c++) begin
            tick(1);
            check("bounce_wait", 32'(kif.key_signal), 32'd0);
        end
        tick(1);
        check("bounce_sig", 32'(kif.key_signal), 32'b10);
        tick(1);
        check("bounce_sig_once", 32'(kif.key_signal), 32'd0);
        kif.key_in[1] = 1'b1;
        tick(15);
        check("bounce_released", 32'(kif.key_level), 32'd0);

        // Last-cycle bounce on key 0: 7 low, 1 high, then held low
        kif.key_in[0] = 1'b0;
        tick(7);
        kif.key_in[0] = 1'b1;
        tick(1);
        kif.key_in[0] = 1'b0;
        for (int c = 0; c < 9; c++) begin
            tick(1);
            check("lastbounce_no_sig", 32'(kif.key_signal), 32'd0);
        end
        tick(1);
        check("lastbounce_sig", 32'(kif.key_signal), 32'b01);

        // Release glitch of 5 cycles while HELD: long lands 45 edges after the pulse
        tick(5);
        kif.key_in[0] = 1'b1;
        tick(5);
        kif.key_in[0] = 1'b0;
        long_cnt = 0;
        long_at  = -1;
        for (int c = 11; c <= 60; c++) begin
            tick(1);
            check("glitch_level", 32'(kif.key_level), 32'b01);
            check("glitch_no_sig", 32'(kif.key_signal), 32'd0);
            if (kif.key_long[0]) begin
                long_cnt++;
                long_at = c;
            end
        end
        check("glitch_long_cnt", 32'(long_cnt), LE ? 32'd1 : 32'd0);
        check("glitch_long_at",  32'(long_at),  LE ? 32'd45 : 32'hFFFF_FFFF);
        kif.key_in[0] = 1'b1;
        tick(12);
        check("glitch_released", 32'(kif.key_level), 32'd0);

        // Simultaneous press on both keys
        kif.key_in = 2'b00;
        tick(9);
        check("simul_early", 32'(kif.key_signal), 32'd0);
        tick(1);
        check("simul_sig", 32'(kif.key_signal), 32'b11);
        tick(1);
        check("simul_sig_once", 32'(kif.key_signal), 32'd0);
        tick(3);

        // Asynchronous reset while HELD, keys still held
        nrst = 1'b0;
        #1;
        check("rst_async_level", 32'(kif.key_level), 32'd0);
        check("rst_async_sig",   32'(kif.key_signal), 32'd0);
        tick(2);
        nrst = 1'b1;
        for (int c = 0; c < 9; c++) begin
            tick(1);
            check("rst_no_pulse", 32'(kif.key_signal), 32'd0);
        end
        tick(1);
        check("rst_repress_sig", 32'(kif.key_signal), 32'b11);
        check("rst_repress_level", 32'(kif.key_level), 32'b11);
        tick(39);
        check("rst_long_early", 32'(kif.key_long), 32'd0);
        tick(1);
        check("rst_long", 32'(kif.key_long), LE ? 32'b11 : 32'd0);
        kif.key_in = 2'b11;
        tick(12);
        check("final_level", 32'(kif.key_level), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
